// File: rtl/varredor_canais.sv
// varredor_canais: masked 8-channel mux scanner; iniciar/continuo/mascara in, endereco out, dados_selecionados sampled after ESPERA settle cycles, dado_saida/canal_saida/valido with pronto handshake, ocupado and fim_varredura status
module varredor_canais #(
  parameter int LARGURA = 8,
  parameter int ESPERA  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               iniciar,
  input  logic               continuo,
  input  logic [7:0]         mascara,
  output logic [2:0]         endereco,
  input  logic [LARGURA-1:0] dados_selecionados,
  output logic [LARGURA-1:0] dado_saida,
  output logic [2:0]         canal_saida,
  output logic               valido,
  input  logic               pronto,
  output logic               ocupado,
  output logic               fim_varredura
);
  typedef enum logic [2:0] {OCIOSO, BUSCA, ESTABILIZA, ENTREGA, FIM} estado_t;
  estado_t estado_q, estado_d;
  logic [2:0] canal_q, canal_d, canal_saida_q, canal_saida_d;
  logic [3:0] cont_q, cont_d;
  logic [7:0] masc_q, masc_d;
  logic [LARGURA-1:0] dado_q, dado_d;
  always_comb begin
    estado_d = estado_q;
    canal_d = canal_q;
    canal_saida_d = canal_saida_q;
    cont_d = cont_q;
    masc_d = masc_q;
    dado_d = dado_q;
    case (estado_q)
      OCIOSO:
        if (iniciar && |mascara) begin
          masc_d = mascara;
          canal_d = '0;
          estado_d = BUSCA;
        end
      BUSCA:
        if (masc_q[canal_q]) begin
          cont_d = 4'(ESPERA - 1);
          estado_d = ESTABILIZA;
        end else if (canal_q == 3'd7) estado_d = FIM;
        else canal_d = canal_q + 3'd1;
      ESTABILIZA:
        if (cont_q == '0) begin
          dado_d = dados_selecionados;
          canal_saida_d = canal_q;
          estado_d = ENTREGA;
        end else cont_d = cont_q - 4'd1;
      ENTREGA:
        if (pronto) begin
          estado_d = canal_q == 3'd7 ? FIM : BUSCA;
          canal_d = canal_q == 3'd7 ? canal_q : canal_q + 3'd1;
        end
      FIM:
        if (continuo && |mascara) begin
          masc_d = mascara;
          canal_d = '0;
          estado_d = BUSCA;
        end else estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= OCIOSO;
      canal_q <= '0;
      canal_saida_q <= '0;
      cont_q <= '0;
      masc_q <= '0;
      dado_q <= '0;
    end else begin
      estado_q <= estado_d;
      canal_q <= canal_d;
      canal_saida_q <= canal_saida_d;
      cont_q <= cont_d;
      masc_q <= masc_d;
      dado_q <= dado_d;
    end
  end
  assign endereco = canal_q;
  assign dado_saida = dado_q;
  assign canal_saida = canal_saida_q;
  assign valido = estado_q == ENTREGA;
  assign ocupado = estado_q != OCIOSO;
  assign fim_varredura = estado_q == FIM;
endmodule

// File: tb/tb_varredor_canais.sv
// tb_varredor_canais: directed checks of varredor_canais with ESPERA=1 and ESPERA=3 instances
module tb_varredor_canais;
  logic clk = 0, rst = 1, iniciar = 0, iniciar3 = 0, continuo = 0, pronto = 1;
  logic [7:0] mascara = 0, d3 = 0;
  logic [7:0] mux_val [8];
  logic [2:0] endereco, canal_saida, endereco3, canal_saida3;
  logic [7:0] dsel, dado_saida, dado_saida3;
  logic valido, ocupado, fim, valido3, ocupado3, fim3;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  assign dsel = mux_val[endereco];
  varredor_canais #(.LARGURA(8), .ESPERA(1)) u1 (
    .clk(clk), .rst(rst), .iniciar(iniciar), .continuo(continuo), .mascara(mascara),
    .endereco(endereco), .dados_selecionados(dsel), .dado_saida(dado_saida),
    .canal_saida(canal_saida), .valido(valido), .pronto(pronto), .ocupado(ocupado),
    .fim_varredura(fim));
  varredor_canais #(.LARGURA(8), .ESPERA(3)) u3 (
    .clk(clk), .rst(rst), .iniciar(iniciar3), .continuo(continuo), .mascara(mascara),
    .endereco(endereco3), .dados_selecionados(d3), .dado_saida(dado_saida3),
    .canal_saida(canal_saida3), .valido(valido3), .pronto(pronto), .ocupado(ocupado3),
    .fim_varredura(fim3));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic sel(input int w);
    return w == 0 ? valido : w == 1 ? fim : w == 2 ? valido3 : fim3;
  endfunction
  task automatic wait_for(input string tag, input int w, input int lim);
    int k = 0;
    while (sel(w) !== 1'b1 && k < lim) begin
      step();
      k++;
    end
    chk(tag, {31'd0, sel(w)}, 32'd1);
  endtask
  initial begin
    for (int i = 0; i < 8; i++) mux_val[i] = 8'h10 + 8'(i);
    step();
    chk("rst_endereco", endereco, 0);
    chk("rst_valido", valido, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_fim", fim, 0);
    chk("rst_dado", dado_saida, 0);
    chk("rst_canal", canal_saida, 0);
    rst = 0;
    mascara = 8'hFF;
    iniciar = 1;
    step();
    iniciar = 0;
    chk("full_ocupado", ocupado, 1);
    for (int i = 0; i < 8; i++) begin
      wait_for("full_wait_valido", 0, 10);
      chk("full_canal", canal_saida, i);
      chk("full_dado", dado_saida, 8'h10 + i);
      iniciar = i == 3;
      step();
      iniciar = 0;
      chk("full_handshake_drop", valido, 0);
    end
    chk("full_fim", fim, 1);
    step();
    chk("full_fim_one_cycle", fim, 0);
    chk("full_idle", ocupado, 0);
    mascara = 8'b1000_0010;
    pronto = 0;
    iniciar = 1;
    step();
    iniciar = 0;
    mascara = 8'hFF;
    wait_for("sparse_wait_valido", 0, 10);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_valido", valido, 1);
      chk("bp_canal", canal_saida, 1);
      chk("bp_dado", dado_saida, 8'h11);
    end
    pronto = 1;
    step();
    chk("bp_one_transfer", valido, 0);
    chk("sparse_endereco", endereco, 2);
    for (int c = 3; c < 8; c++) begin
      step();
      chk("sparse_busca_endereco", endereco, c);
      chk("sparse_busca_valido", valido, 0);
    end
    step();
    chk("sparse_settle_valido", valido, 0);
    step();
    chk("sparse_valido7", valido, 1);
    chk("sparse_canal7", canal_saida, 7);
    chk("sparse_dado7", dado_saida, 8'h17);
    step();
    chk("sparse_fim", fim, 1);
    step();
    chk("sparse_fim_drop", fim, 0);
    chk("sparse_idle", ocupado, 0);
    mascara = 0;
    iniciar = 1;
    step();
    chk("zero_mask_ocupado", ocupado, 0);
    chk("zero_mask_fim", fim, 0);
    step();
    chk("zero_mask_ocupado2", ocupado, 0);
    iniciar = 0;
    mascara = 8'h01;
    continuo = 1;
    iniciar = 1;
    step();
    iniciar = 0;
    wait_for("cont_fim1", 1, 20);
    step();
    chk("cont_fim1_drop", fim, 0);
    wait_for("cont_fim2", 1, 20);
    step();
    wait_for("cont_valido", 0, 10);
    #2 rst = 1;
    #1;
    chk("async_valido", valido, 0);
    chk("async_ocupado", ocupado, 0);
    chk("async_endereco", endereco, 0);
    chk("async_fim", fim, 0);
    step();
    chk("rst_hold_fim", fim, 0);
    continuo = 0;
    rst = 0;
    iniciar = 1;
    step();
    iniciar = 0;
    chk("post_rst_start", ocupado, 1);
    wait_for("post_rst_fim", 1, 20);
    step();
    chk("post_rst_idle", ocupado, 0);
    mascara = 8'h04;
    d3 = 8'hAA;
    iniciar3 = 1;
    step();
    iniciar3 = 0;
    step();
    step();
    chk("settle_endereco", endereco3, 2);
    step();
    chk("settle_c1", valido3, 0);
    step();
    chk("settle_c2", valido3, 0);
    d3 = 8'hBB;
    step();
    chk("settle_c3", valido3, 0);
    d3 = 8'hCC;
    step();
    chk("settle_valido", valido3, 1);
    chk("settle_dado", dado_saida3, 8'hCC);
    chk("settle_canal", canal_saida3, 2);
    d3 = 8'hDD;
    wait_for("settle_fim", 3, 20);
    step();
    chk("settle_idle", ocupado3, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
